// File: rtl/vpu_obj_pkg.sv
// Shared definitions for the VPU object bookkeeping blocks: the command
// priority encoding and the slot-index width helper.
package vpu_obj_pkg;

    // Winning command after priority resolution, highest priority first.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_DEL_ALL,
        CMD_DEL,
        CMD_CRT,
        CMD_REF
    } cmd_e;

    // Index width needed to address n slots; never narrower than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_pri_enc.sv
// Rotating priority encoder: grants the first set request found when
// scanning upward from base, wrapping past N-1 back to 0.
module rr_pri_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    logic found;
    int   pos;

    // Scan all positions starting at base; the first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path leaves it unassigned and no latch is inferred.
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(base) + i;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                found   = 1'b1;
                gnt_idx = W'(pos);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/obj_table_unit.sv
// Object allocation table: allocates/frees video-memory slots on commands
// from the matrix unit, answers address lookups and keeps a dirty bitmap
// drained round-robin by the raster/clipping stage.
module obj_table_unit
    import vpu_obj_pkg::*;
#(
    parameter  int NUM_OBJ = 32,
    localparam int IDX_W   = idx_width(NUM_OBJ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               crt_obj,
    input  logic               del_obj,
    input  logic               del_all,
    input  logic               ref_addr,
    input  logic               changed_in,
    input  logic [IDX_W-1:0]   obj_num,
    output logic [IDX_W-1:0]   addr,
    output logic               addr_vld,
    output logic [IDX_W-1:0]   lst_stored_obj,
    output logic               lst_stored_obj_vld,
    output logic               obj_mem_full,
    output logic [IDX_W:0]     obj_count,
    output logic [NUM_OBJ-1:0] obj_map,
    output logic               cmd_err,
    output logic               dirty_vld,
    output logic [IDX_W-1:0]   dirty_idx,
    input  logic               dirty_ack
);

    localparam int CNT_W = IDX_W + 1;

    logic [NUM_OBJ-1:0] obj_map_q, obj_map_d;
    logic [NUM_OBJ-1:0] dirty_q, dirty_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   obj_count_q, obj_count_d;
    logic               full_q, full_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic               addr_vld_q, addr_vld_d;
    logic [IDX_W-1:0]   lst_q, lst_d;
    logic               lst_vld_q, lst_vld_d;
    logic               cmd_err_q, cmd_err_d;

    logic [IDX_W-1:0]   free_idx;
    logic               free_any;
    logic [IDX_W-1:0]   drain_idx;
    logic               drain_any;

    cmd_e               cmd;
    logic [2:0]         n_cmd;

    // Lowest free slot: fixed scan from slot 0 over unmapped slots.
    rr_pri_enc #(.N(NUM_OBJ), .W(IDX_W)) u_free_enc (
        .req     (~obj_map_q),
        .base    ('0),
        .gnt_idx (free_idx),
        .any     (free_any)
    );

    // Next dirty slot for the consumer, rotating from rr_ptr.
    rr_pri_enc #(.N(NUM_OBJ), .W(IDX_W)) u_dirty_enc (
        .req     (dirty_q),
        .base    (rr_ptr_q),
        .gnt_idx (drain_idx),
        .any     (drain_any)
    );

    // Command decode, then next state: ack first, command second, changed_in
    // last, so del/del_all override an ack and a set beats a same-slot ack.
    always_comb begin
        n_cmd = 3'(del_all) + 3'(del_obj) + 3'(crt_obj) + 3'(ref_addr);
        if (del_all)       cmd = CMD_DEL_ALL;
        else if (del_obj)  cmd = CMD_DEL;
        else if (crt_obj)  cmd = CMD_CRT;
        else if (ref_addr) cmd = CMD_REF;
        else               cmd = CMD_NONE;

        obj_map_d   = obj_map_q;
        dirty_d     = dirty_q;
        rr_ptr_d    = rr_ptr_q;
        obj_count_d = obj_count_q;
        addr_d      = addr_q;
        lst_d       = lst_q;
        addr_vld_d  = 1'b0;
        lst_vld_d   = 1'b0;
        cmd_err_d   = (n_cmd > 3'd1);

        if (drain_any && dirty_ack) begin
            dirty_d[drain_idx] = 1'b0;
            rr_ptr_d           = drain_idx + 1'b1;  // wraps: NUM_OBJ is 2**IDX_W
        end

        case (cmd)
            CMD_DEL_ALL: begin
                obj_map_d   = '0;
                dirty_d     = '0;
                obj_count_d = '0;
                rr_ptr_d    = '0;
            end
            CMD_DEL: begin
                if (obj_map_q[obj_num]) begin
                    obj_map_d[obj_num] = 1'b0;
                    dirty_d[obj_num]   = 1'b0;
                    obj_count_d        = obj_count_q - 1'b1;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end
            CMD_CRT: begin
                if (free_any) begin
                    obj_map_d[free_idx] = 1'b1;
                    dirty_d[free_idx]   = 1'b1;
                    obj_count_d         = obj_count_q + 1'b1;
                    lst_d               = free_idx;
                    addr_d              = free_idx;
                    lst_vld_d           = 1'b1;
                    addr_vld_d          = 1'b1;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end
            CMD_REF: begin
                addr_d = obj_num;
                if (obj_map_q[obj_num]) addr_vld_d = 1'b1;
                else                    cmd_err_d  = 1'b1;
            end
            default: begin
            end
        endcase

        // Only slots still mapped after this cycle's command can become dirty.
        if (changed_in && obj_map_d[obj_num]) dirty_d[obj_num] = 1'b1;

        full_d = (obj_count_d == CNT_W'(NUM_OBJ));
    end

    // All table state and result pulses; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_map_q   <= '0;
            dirty_q     <= '0;
            rr_ptr_q    <= '0;
            obj_count_q <= '0;
            full_q      <= 1'b0;
            addr_q      <= '0;
            addr_vld_q  <= 1'b0;
            lst_q       <= '0;
            lst_vld_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the
            // pre-edge values and ordering inside the block cannot matter.
            obj_map_q   <= obj_map_d;
            dirty_q     <= dirty_d;
            rr_ptr_q    <= rr_ptr_d;
            obj_count_q <= obj_count_d;
            full_q      <= full_d;
            addr_q      <= addr_d;
            addr_vld_q  <= addr_vld_d;
            lst_q       <= lst_d;
            lst_vld_q   <= lst_vld_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign obj_map            = obj_map_q;
    assign obj_count          = obj_count_q;
    assign obj_mem_full       = full_q;
    assign addr               = addr_q;
    assign addr_vld           = addr_vld_q;
    assign lst_stored_obj     = lst_q;
    assign lst_stored_obj_vld = lst_vld_q;
    assign cmd_err            = cmd_err_q;
    assign dirty_vld          = drain_any;
    assign dirty_idx          = drain_idx;

endmodule
